// File: rtl/key_event_fifo.sv
// Key event FIFO: captures debounced key presses and exposes them to the CPU
// through a synchronized SRAM-style read port with a DATA and a STATUS register.
module key_event_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter bit PUSH_RELEASE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       ncs,
  input  logic       noe,
  input  logic       addr,
  output logic [7:0] rd_data,
  output logic       irq
);

  logic [7:0]    key_q;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    ncs_sync_q, noe_sync_q, addr_sync_q;
  logic          noe_prev_q;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          irq_q, irq_d;
  logic [7:0]    mem_q [DEPTH];

  logic       ncs_s, noe_s, addr_s;
  logic       empty, full;
  logic       push_req, do_push, do_pop, rd_end, ovf_set, stat_clr;
  logic [4:0] cnt_field;

  assign ncs_s  = ncs_sync_q[1];
  assign noe_s  = noe_sync_q[1];
  assign addr_s = addr_sync_q[1];

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == (AW+1)'(DEPTH));
    cnt_field = 5'(cnt_q);

    push_req = ((key_code != key_q) && (key_code != '0)) ||
               (PUSH_RELEASE && (key_code == '0) && (key_q != '0));

    // End of an access: synchronized output enable rising while still selected.
    rd_end   = noe_s && !noe_prev_q && !ncs_s;
    stat_clr = rd_end && addr_s;
    do_pop   = rd_end && !addr_s && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    do_push  = push_req && (!full || do_pop);
    ovf_set  = push_req && full && !do_pop;

    wp_d  = do_push ? wp_q + 1'b1 : wp_q;
    rp_d  = do_pop  ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;

    ovf_d = ovf_q;
    if (ovf_set)       ovf_d = 1'b1;
    else if (stat_clr) ovf_d = 1'b0;

    if (addr_s)     rd_data_d = {full, empty, ovf_q, cnt_field};
    else if (empty) rd_data_d = '0;
    else            rd_data_d = mem_q[rp_q];

    irq_d = !empty || ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q       <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      ncs_sync_q  <= '1;
      noe_sync_q  <= '1;
      addr_sync_q <= '1;
      noe_prev_q  <= 1'b1;
      rd_data_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      key_q       <= key_code;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      ncs_sync_q  <= {ncs_sync_q[0], ncs};
      noe_sync_q  <= {noe_sync_q[0], noe};
      addr_sync_q <= {addr_sync_q[0], addr};
      noe_prev_q  <= noe_s;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= key_code;
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule
